// File: rtl/mask_upscale_buffer_if.sv
// Signal bundle between the binning/display producers and mask_upscale_buffer.
// The master side drives the binned stream and display requests. The slave side returns the upscaled pixels.
interface mask_upscale_buffer_if #(
    parameter int HRES        = 1280,
    parameter int VRES        = 720,
    parameter int KERNEL_SIZE = 4
);
    localparam int KSHIFT = $clog2(KERNEL_SIZE);
    localparam int HWIDTH = $clog2(HRES);
    localparam int VWIDTH = $clog2(VRES);

    logic                     bin_pixel_in;
    logic [HWIDTH-KSHIFT-1:0] bin_hcount_in;
    logic [VWIDTH-KSHIFT-1:0] bin_vcount_in;
    logic                     bin_valid_in;
    logic [HWIDTH-1:0]        hcount_in;
    logic [VWIDTH-1:0]        vcount_in;
    logic                     data_valid_in;
    logic                     pixel_data_out;
    logic [HWIDTH-1:0]        hcount_out;
    logic [VWIDTH-1:0]        vcount_out;
    logic                     data_valid_out;
    logic                     frame_swap_out;
    logic [7:0]               dropped_frames_out;

    modport master (
        output bin_pixel_in, bin_hcount_in, bin_vcount_in, bin_valid_in,
        output hcount_in, vcount_in, data_valid_in,
        input  pixel_data_out, hcount_out, vcount_out, data_valid_out,
        input  frame_swap_out, dropped_frames_out
    );

    modport slave (
        input  bin_pixel_in, bin_hcount_in, bin_vcount_in, bin_valid_in,
        input  hcount_in, vcount_in, data_valid_in,
        output pixel_data_out, hcount_out, vcount_out, data_valid_out,
        output frame_swap_out, dropped_frames_out
    );
endinterface

// File: rtl/mask_upscale_buffer.sv
// Ping-pong buffer for the binned mask frames. The display scan reads it back with
// nearest-neighbour replication, so each binned pixel is shown as a KERNEL_SIZE x KERNEL_SIZE block.
module mask_upscale_buffer #(
    parameter int HRES        = 1280,
    parameter int VRES        = 720,
    parameter int KERNEL_SIZE = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    mask_upscale_buffer_if.slave    bus
);
    localparam int KSHIFT = $clog2(KERNEL_SIZE);
    localparam int BHRES  = HRES / KERNEL_SIZE;
    localparam int BVRES  = VRES / KERNEL_SIZE;
    localparam int HWIDTH = $clog2(HRES);
    localparam int VWIDTH = $clog2(VRES);
    localparam int LW     = $clog2(BHRES * BVRES);
    localparam int AW     = LW + 1;
    localparam int STAGES = 3;

    // The bank bit is the address MSB, so each bank occupies a power-of-two span.
    logic mem [2**AW];

    logic          wr_bank, rd_bank, rd_bank_next;
    logic          pending, armed, shown_valid;
    logic [7:0]    drop_cnt;
    logic          we_q, wr_data_q, done_q;
    logic [AW-1:0] wr_addr_q, rd_addr_q;
    logic          rd_data_r1, rd_data_q;

    logic          bin_in_range, bin_origin, bin_last, pend_any, accept, drop;
    logic          disp_origin, swap;
    logic [LW-1:0] wr_lin, rd_lin;

    logic [STAGES:1]             vld_pipe;
    logic [STAGES:1][HWIDTH-1:0] h_pipe;
    logic [STAGES:1][VWIDTH-1:0] v_pipe;

    assign bin_in_range = (int'(bus.bin_hcount_in) < BHRES) && (int'(bus.bin_vcount_in) < BVRES);
    assign bin_origin   = (bus.bin_hcount_in == '0) && (bus.bin_vcount_in == '0);
    assign bin_last     = (int'(bus.bin_hcount_in) == BHRES - 1) && (int'(bus.bin_vcount_in) == BVRES - 1);
    // A frame whose last beat is still in the write pipeline counts as pending already.
    assign pend_any     = pending | done_q;
    assign accept       = bus.bin_valid_in && bin_in_range && !pend_any && (armed || bin_origin);
    assign drop         = bus.bin_valid_in && bin_origin && pend_any;
    assign wr_lin       = LW'(bus.bin_vcount_in) * LW'(BHRES) + LW'(bus.bin_hcount_in);

    assign disp_origin  = bus.data_valid_in && (bus.hcount_in == '0) && (bus.vcount_in == '0);
    assign swap         = disp_origin && pending;
    assign rd_bank      = ~wr_bank;
    assign rd_bank_next = swap ? wr_bank : rd_bank;
    assign rd_lin       = LW'(bus.vcount_in >> KSHIFT) * LW'(BHRES) + LW'(bus.hcount_in >> KSHIFT);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            we_q        <= 1'b0;
            wr_data_q   <= 1'b0;
            wr_addr_q   <= '0;
            done_q      <= 1'b0;
            armed       <= 1'b0;
            pending     <= 1'b0;
            wr_bank     <= 1'b0;
            shown_valid <= 1'b0;
            drop_cnt    <= 8'd0;
        end else begin
            we_q      <= accept;
            wr_data_q <= bus.bin_pixel_in;
            wr_addr_q <= {wr_bank, wr_lin};
            done_q    <= accept && bin_last;
            if (accept && bin_last)
                armed <= 1'b0;
            else if (accept && bin_origin)
                armed <= 1'b1;
            if (done_q)
                pending <= 1'b1;
            else if (swap)
                pending <= 1'b0;
            if (swap) begin
                wr_bank     <= ~wr_bank;
                shown_valid <= 1'b1;
            end
            if (drop && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (we_q)
            mem[wr_addr_q] <= wr_data_q;
        rd_data_r1 <= mem[rd_addr_q];
        rd_data_q  <= rd_data_r1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_addr_q <= '0;
            vld_pipe  <= '0;
            h_pipe    <= '0;
            v_pipe    <= '0;
        end else begin
            rd_addr_q <= {rd_bank_next, rd_lin};
            vld_pipe  <= {vld_pipe[STAGES-1:1], bus.data_valid_in};
            h_pipe    <= {h_pipe[STAGES-1:1], bus.hcount_in};
            v_pipe    <= {v_pipe[STAGES-1:1], bus.vcount_in};
        end
    end

    assign bus.pixel_data_out     = vld_pipe[STAGES] & shown_valid & rd_data_q;
    assign bus.data_valid_out     = vld_pipe[STAGES];
    assign bus.hcount_out         = h_pipe[STAGES];
    assign bus.vcount_out         = v_pipe[STAGES];
    assign bus.frame_swap_out     = swap;
    assign bus.dropped_frames_out = drop_cnt;
endmodule
